// File: rtl/cache_assoc_wb.sv
// ---------------------------------------------------------------------------
// cache_assoc_wb : N-way set-associative write-back, write-allocate data cache
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cache_assoc_wb #(
  parameter int ARCH_BITS = 32,
  parameter int LINE_BITS = 128,
  parameter int SETS      = 4,
  parameter int WAYS      = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cpu_req_i,
  input  logic                 cpu_we_i,
  input  logic [ARCH_BITS-1:0] cpu_addr_i,
  input  logic [ARCH_BITS-1:0] cpu_wdata_i,
  output logic [ARCH_BITS-1:0] cpu_rdata_o,
  output logic                 cpu_hit_o,
  output logic                 cpu_stall_o,
  output logic [ARCH_BITS-1:0] mem_raddr_o,
  output logic                 mem_rreq_o,
  input  logic [LINE_BITS-1:0] mem_rline_i,
  input  logic                 mem_rvalid_i,
  output logic [ARCH_BITS-1:0] mem_waddr_o,
  output logic [LINE_BITS-1:0] mem_wline_o,
  output logic                 mem_wreq_o,
  input  logic                 mem_wack_i
);

  localparam int OFF_B  = $clog2(ARCH_BITS / 8);
  localparam int WPL    = LINE_BITS / ARCH_BITS;
  localparam int OFF_W  = (WPL > 1) ? $clog2(WPL) : 0;
  localparam int WSEL_B = (OFF_W > 0) ? OFF_W : 1;
  localparam int IDX    = $clog2(SETS);
  localparam int TAG    = ARCH_BITS - OFF_B - OFF_W - IDX;
  localparam int WAY_B  = (WAYS > 1) ? $clog2(WAYS) : 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WB      = 2'd1;
  localparam logic [1:0] S_REFILL  = 2'd2;
  localparam logic [1:0] S_INSTALL = 2'd3;

  logic [LINE_BITS-1:0] data_q  [SETS][WAYS];
  logic [TAG-1:0]       tag_q   [SETS][WAYS];
  logic [WAY_B-1:0]     age_q   [SETS][WAYS];
  logic [WAYS-1:0]      valid_q [SETS];
  logic [WAYS-1:0]      dirty_q [SETS];

  logic [1:0]           state_q, state_d;
  logic [WAY_B-1:0]     vict_q;
  logic [IDX-1:0]       mset_q;
  logic [TAG-1:0]       mtag_q;
  logic [LINE_BITS-1:0] rline_q;

  logic [TAG-1:0]       w_tag;
  logic [IDX-1:0]       w_set;
  logic [WSEL_B-1:0]    w_word;
  logic                 w_hit_any, w_hit, w_miss, w_vfound;
  logic [WAY_B-1:0]     w_hit_way, w_vict;
  logic [LINE_BITS-1:0] w_hit_line;
  logic                 w_unused;

  assign w_tag    = cpu_addr_i[ARCH_BITS-1 -: TAG];
  assign w_set    = cpu_addr_i[OFF_B+OFF_W +: IDX];
  assign w_unused = &{1'b0, cpu_addr_i[OFF_B-1:0]};

  generate
    if (OFF_W > 0) begin : g_word_sel
      assign w_word = cpu_addr_i[OFF_B +: OFF_W];
    end else begin : g_word_none
      assign w_word = '0;
    end
  endgenerate

  always_comb begin
    w_hit_any = 1'b0;
    w_hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[w_set][w] && (tag_q[w_set][w] == w_tag)) begin
        w_hit_any = 1'b1;
        w_hit_way = WAY_B'(w);
      end
    end
    // Invalid ways are preferred; otherwise the oldest (age WAYS-1) is evicted.
    w_vict   = '0;
    w_vfound = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!w_vfound && !valid_q[w_set][w]) begin
        w_vict   = WAY_B'(w);
        w_vfound = 1'b1;
      end
    end
    if (!w_vfound) begin
      for (int w = 0; w < WAYS; w++) begin
        if (age_q[w_set][w] == WAY_B'(WAYS - 1)) w_vict = WAY_B'(w);
      end
    end
  end

  assign w_hit      = cpu_req_i && (state_q == S_IDLE) && w_hit_any;
  assign w_miss     = cpu_req_i && (state_q == S_IDLE) && !w_hit_any;
  assign w_hit_line = data_q[w_set][w_hit_way];

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (w_miss) state_d = (valid_q[w_set][w_vict] && dirty_q[w_set][w_vict]) ? S_WB : S_REFILL;
      S_WB:      if (mem_wack_i) state_d = S_REFILL;
      S_REFILL:  if (mem_rvalid_i) state_d = S_INSTALL;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cpu_hit_o   = 1'b0;
    cpu_rdata_o = '0;
    mem_rreq_o  = 1'b0;
    mem_raddr_o = '0;
    mem_wreq_o  = 1'b0;
    mem_waddr_o = '0;
    mem_wline_o = '0;
    case (state_q)
      S_IDLE: begin
        if (cpu_req_i && w_hit_any) begin
          cpu_hit_o   = 1'b1;
          cpu_rdata_o = w_hit_line[w_word*ARCH_BITS +: ARCH_BITS];
        end
      end
      S_WB: begin
        mem_wreq_o  = 1'b1;
        mem_waddr_o = {tag_q[mset_q][vict_q], mset_q, {(OFF_W+OFF_B){1'b0}}};
        mem_wline_o = data_q[mset_q][vict_q];
      end
      S_REFILL: begin
        mem_rreq_o  = 1'b1;
        mem_raddr_o = {mtag_q, mset_q, {(OFF_W+OFF_B){1'b0}}};
      end
      default: ;
    endcase
    cpu_stall_o = cpu_req_i && !cpu_hit_o;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) age_q[s][w] <= WAY_B'(w);
      end
      vict_q  <= '0;
      mset_q  <= '0;
      mtag_q  <= '0;
      rline_q <= '0;
    end else begin
      if (w_hit) begin
        if (cpu_we_i) begin
          data_q[w_set][w_hit_way][w_word*ARCH_BITS +: ARCH_BITS] <= cpu_wdata_i;
          dirty_q[w_set][w_hit_way] <= 1'b1;
        end
        for (int w = 0; w < WAYS; w++) begin
          if (WAY_B'(w) == w_hit_way) age_q[w_set][w] <= '0;
          else if (age_q[w_set][w] < age_q[w_set][w_hit_way]) age_q[w_set][w] <= age_q[w_set][w] + 1'b1;
        end
      end
      if (w_miss) begin
        vict_q <= w_vict;
        mset_q <= w_set;
        mtag_q <= w_tag;
      end
      if ((state_q == S_REFILL) && mem_rvalid_i) rline_q <= mem_rline_i;
      if (state_q == S_INSTALL) begin
        data_q[mset_q][vict_q]  <= rline_q;
        tag_q[mset_q][vict_q]   <= mtag_q;
        valid_q[mset_q][vict_q] <= 1'b1;
        dirty_q[mset_q][vict_q] <= 1'b0;
        for (int w = 0; w < WAYS; w++) begin
          if (WAY_B'(w) == vict_q) age_q[mset_q][w] <= '0;
          else if (age_q[mset_q][w] < age_q[mset_q][vict_q]) age_q[mset_q][w] <= age_q[mset_q][w] + 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cache_assoc_wb.sv
// ---------------------------------------------------------------------------
// tb_cache_assoc_wb : directed + random bench with a timestamp-LRU cache model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_cache_assoc_wb;

  logic         clk = 1'b0;
  logic         rst;
  logic         cpu_req_i, cpu_we_i;
  logic [31:0]  cpu_addr_i, cpu_wdata_i, cpu_rdata_o;
  logic         cpu_hit_o, cpu_stall_o;
  logic [31:0]  mem_raddr_o, mem_waddr_o;
  logic         mem_rreq_o, mem_wreq_o, mem_rvalid_i, mem_wack_i;
  logic [127:0] mem_rline_i, mem_wline_o;

  cache_assoc_wb dut (
    .clk(clk), .rst(rst),
    .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
    .cpu_wdata_i(cpu_wdata_i), .cpu_rdata_o(cpu_rdata_o), .cpu_hit_o(cpu_hit_o),
    .cpu_stall_o(cpu_stall_o), .mem_raddr_o(mem_raddr_o), .mem_rreq_o(mem_rreq_o),
    .mem_rline_i(mem_rline_i), .mem_rvalid_i(mem_rvalid_i), .mem_waddr_o(mem_waddr_o),
    .mem_wline_o(mem_wline_o), .mem_wreq_o(mem_wreq_o), .mem_wack_i(mem_wack_i)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // Model: per-set ways with a last-use timestamp; victim is the least recently used.
  bit           mv   [4][2];
  bit           md   [4][2];
  logic [25:0]  mt   [4][2];
  logic [127:0] mdat [4][2];
  int unsigned  mts  [4][2];
  int unsigned  now;
  logic [127:0] mem [logic [31:0]];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] line_of(input logic [31:0] la);
    if (mem.exists(la)) return mem[la];
    return {la ^ 32'hC0DE0003, la + 32'h33, ~la, la ^ 32'h12345678};
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 4; s++)
      for (int w = 0; w < 2; w++) begin
        mv[s][w] = 0; md[s][w] = 0; mts[s][w] = 0;
      end
  endtask

  task automatic access(input bit we, input logic [31:0] a, input logic [31:0] wd,
                        input int wl, input int rl);
    int s, wi, hw, v;
    bit hit;
    logic [25:0] t;
    logic [31:0] la, va;
    s  = int'(a[5:4]);
    wi = int'(a[3:2]);
    t  = a[31:6];
    la = {a[31:4], 4'h0};
    @(negedge clk);
    cpu_req_i = 1'b1; cpu_we_i = we; cpu_addr_i = a; cpu_wdata_i = wd;
    #1;
    hit = 0; hw = 0;
    for (int i = 0; i < 2; i++) if (mv[s][i] && mt[s][i] == t) begin hit = 1; hw = i; end
    if (!hit) begin
      chk("miss_hit", cpu_hit_o, 0);
      chk("miss_stall", cpu_stall_o, 1);
      v = -1;
      for (int i = 0; i < 2; i++) if (v < 0 && !mv[s][i]) v = i;
      if (v < 0) v = (mts[s][0] < mts[s][1]) ? 0 : 1;
      @(negedge clk);
      if (mv[s][v] && md[s][v]) begin
        va = {mt[s][v], 2'(s), 4'h0};
        for (int i = 0; i <= wl; i++) begin
          mem_wack_i = (i == wl);
          #1;
          chk("wb_wreq", mem_wreq_o, 1);
          chk("wb_rreq", mem_rreq_o, 0);
          chk("wb_waddr", mem_waddr_o, va);
          chk("wb_wline", mem_wline_o, mdat[s][v]);
          @(negedge clk);
        end
        mem_wack_i = 1'b0;
        mem[va] = mdat[s][v];
      end
      for (int i = 0; i <= rl; i++) begin
        mem_rvalid_i = (i == rl);
        mem_rline_i  = (i == rl) ? line_of(la) : {4{$urandom()}};
        #1;
        chk("rf_rreq", mem_rreq_o, 1);
        chk("rf_wreq", mem_wreq_o, 0);
        chk("rf_raddr", mem_raddr_o, la);
        chk("rf_stall", cpu_stall_o, 1);
        @(negedge clk);
      end
      mem_rvalid_i = 1'b0;
      #1;
      chk("inst_hit", cpu_hit_o, 0);
      chk("inst_req", {mem_rreq_o, mem_wreq_o}, 0);
      mv[s][v] = 1; md[s][v] = 0; mt[s][v] = t; mdat[s][v] = line_of(la);
      mts[s][v] = ++now;
      hw = v;
      @(negedge clk);
      #1;
    end
    chk("hit", cpu_hit_o, 1);
    chk("hit_stall", cpu_stall_o, 0);
    if (!we) chk("rdata", cpu_rdata_o, mdat[s][hw][wi*32 +: 32]);
    else begin
      mdat[s][hw][wi*32 +: 32] = wd;
      md[s][hw] = 1;
    end
    mts[s][hw] = ++now;
  endtask

  task automatic idle_check();
    @(negedge clk);
    cpu_req_i = 1'b0;
    #1;
    chk("idle_out", {cpu_hit_o, cpu_stall_o, mem_rreq_o, mem_wreq_o}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a;
    rst = 1'b1;
    cpu_req_i = 0; cpu_we_i = 0; cpu_addr_i = 0; cpu_wdata_i = 0;
    mem_rvalid_i = 0; mem_wack_i = 0; mem_rline_i = '0;
    now = 0;
    model_reset();
    mem[32'h100] = {32'h3, 32'h2, 32'h1, 32'hA5};
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out", {cpu_hit_o, cpu_stall_o, mem_rreq_o, mem_wreq_o}, 0);
    chk("rst_addr", {mem_raddr_o, mem_waddr_o}, 0);
    chk("rst_wline", mem_wline_o, 0);

    access(0, 32'h100, 0, 0, 2);                 // T1
    chk("t1_word0", cpu_rdata_o, 32'hA5);
    access(0, 32'h140, 0, 0, 0);                 // T2
    access(0, 32'h180, 0, 0, 1);
    access(1, 32'h104, 32'hDEAD, 0, 0);          // T3
    access(0, 32'h140, 0, 0, 0);
    access(0, 32'h180, 0, 20, 1);                // T4: dirty 0x100 written back, slow ack
    chk("t3_mem", mem[32'h100][63:32], 32'hDEAD);
    access(1, 32'h200, 32'h1234, 2, 0);          // T5
    access(0, 32'h200, 0, 0, 0);
    chk("t5_rdata", cpu_rdata_o, 32'h1234);

    // Stray memory pulses while idle must not disturb anything.
    @(negedge clk);
    cpu_req_i = 0; mem_rvalid_i = 1; mem_wack_i = 1;
    @(negedge clk);
    mem_rvalid_i = 0; mem_wack_i = 0;
    #1;
    chk("stray", {cpu_hit_o, cpu_stall_o, mem_rreq_o, mem_wreq_o}, 0);
    access(0, 32'h200, 0, 0, 0);

    // T6: reset while refilling set 3.
    @(negedge clk);
    cpu_req_i = 1; cpu_we_i = 0; cpu_addr_i = 32'h3F0;
    @(negedge clk);
    #1;
    chk("t6_rreq", mem_rreq_o, 1);
    @(negedge clk);
    rst = 1'b1; cpu_req_i = 0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t6_after", {cpu_hit_o, cpu_stall_o, mem_rreq_o, mem_wreq_o}, 0);
    model_reset();
    access(0, 32'h200, 0, 0, 1);

    for (int n = 0; n < 200; n++) begin
      a = ($urandom_range(0, 5) << 6) | ($urandom_range(0, 3) << 4) | ($urandom_range(0, 3) << 2);
      access(1'($urandom_range(0, 1)), a, $urandom(), $urandom_range(0, 3), $urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) idle_check();
    end

    @(negedge clk);
    cpu_req_i = 0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

`default_nettype wire
